// File: rtl/down_count_monitor_if.sv
// Bus between the down-counter consumer and its environment: sampled count,
// stats clear, and the monitor's registered status/tally outputs.
interface down_count_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] count_in;
  logic             clr_stats;
  logic             locked;
  logic             tc_pulse;
  logic             wrap_pulse;
  logic             seq_err;
  logic [CNT_W-1:0] wrap_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output count_in, clr_stats,
    input  locked, tc_pulse, wrap_pulse, seq_err, wrap_cnt, err_cnt
  );

  modport slave (
    input  count_in, clr_stats,
    output locked, tc_pulse, wrap_pulse, seq_err, wrap_cnt, err_cnt
  );
endinterface

// File: rtl/down_count_monitor.sv
// Locks onto a legal decrement sequence on count_in and reports terminal-count,
// wrap and sequence-error events plus saturating wrap/error tallies.
//
// state   | meaning
// IDLE    | first sample after reset; capture prev only
// ACQUIRE | counting consecutive legal decrements toward LOCK_N
// TRACK   | locked; emits tc/wrap pulses, flags illegal steps
// FAULT   | one-cycle recovery after an illegal step
module down_count_monitor #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 2
) (
  input logic            clk,
  input logic            rst,
  down_count_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, FAULT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [2:0]       run;
  logic             locked_q;
  logic             tc_q;
  logic             wrap_q;
  logic             err_q;
  logic [CNT_W-1:0] wrap_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] prev_m1;
  logic [2:0]       run_inc;
  logic             dec;
  logic             hold;

  assign cur     = bus.count_in;
  assign prev_m1 = prev - WIDTH'(1);
  assign run_inc = run + 3'd1;
  assign dec     = (cur == prev_m1);
  assign hold    = (cur == prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      locked_q   <= 1'b0;
      tc_q       <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      wrap_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      prev   <= cur;
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          state <= ACQUIRE;
          run   <= '0;
        end
        ACQUIRE: begin
          if (dec) begin
            run <= run_inc;
            if (run_inc == 3'(LOCK_N)) begin
              state    <= TRACK;
              locked_q <= 1'b1;
            end
          end else if (!hold) begin
            run <= '0;
          end
        end
        TRACK: begin
          if (dec) begin
            tc_q   <= (cur == '0);
            wrap_q <= (prev == '0);
            if (prev == '0 && wrap_cnt_q != CNT_MAX)
              wrap_cnt_q <= wrap_cnt_q + CNT_W'(1);
          end else if (!hold) begin
            state    <= FAULT;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
            if (err_cnt_q != CNT_MAX)
              err_cnt_q <= err_cnt_q + CNT_W'(1);
          end
        end
        FAULT: begin
          state <= ACQUIRE;
          run   <= '0;
        end
        default: begin
          state    <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
      // Clear overrides any increment made on the same edge.
      if (bus.clr_stats) begin
        wrap_cnt_q <= '0;
        err_cnt_q  <= '0;
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.tc_pulse   = tc_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.seq_err    = err_q;
  assign bus.wrap_cnt   = wrap_cnt_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench: default monitor plus a CNT_W=2 copy fed the same count stream.
module tb_down_count_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  down_count_monitor_if #(.WIDTH(4), .CNT_W(8)) ifa ();
  down_count_monitor_if #(.WIDTH(4), .CNT_W(2)) ifb ();

  down_count_monitor #(.WIDTH(4), .CNT_W(8), .LOCK_N(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  down_count_monitor #(.WIDTH(4), .CNT_W(2), .LOCK_N(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [3:0] v);
    ifa.count_in = v;
    ifb.count_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic set_clr(input logic c);
    ifa.clr_stats = c;
    ifb.clr_stats = c;
  endtask

  int sat_exp [4] = '{2, 3, 3, 3};

  initial begin
    set_clr(1'b0);
    rst = 1'b1;

    // reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick(4'd15);
      chk("rst_locked", ifa.locked, 0);
    end
    chk("rst_tc", ifa.tc_pulse, 0);
    chk("rst_wrap", ifa.wrap_pulse, 0);
    chk("rst_err", ifa.seq_err, 0);
    chk("rst_wcnt", ifa.wrap_cnt, 0);
    chk("rst_ecnt", ifa.err_cnt, 0);

    // free run: lock after second legal decrement
    rst = 1'b0;
    tick(4'd15); chk("acq_idle", ifa.locked, 0);
    tick(4'd14); chk("acq_dec1", ifa.locked, 0);
    tick(4'd13); chk("acq_dec2", ifa.locked, 1);
    for (int v = 12; v >= 1; v--) begin
      tick(4'(v));
      chk("run_tc", ifa.tc_pulse, 0);
      chk("run_wrap", ifa.wrap_pulse, 0);
    end
    tick(4'd0);  chk("tc1", ifa.tc_pulse, 1); chk("tc1_wrap", ifa.wrap_pulse, 0);
    tick(4'd15); chk("wrap1", ifa.wrap_pulse, 1); chk("wrap1_tc", ifa.tc_pulse, 0);
    chk("wcnt1", ifa.wrap_cnt, 1);
    for (int lap = 2; lap <= 3; lap++) begin
      for (int v = 14; v >= 1; v--) begin
        tick(4'(v));
        chk("lap_tc", ifa.tc_pulse, 0);
      end
      tick(4'd0);  chk("lap_tc0", ifa.tc_pulse, 1);
      tick(4'd15); chk("lap_wrap", ifa.wrap_pulse, 1);
      chk("lap_wcnt", ifa.wrap_cnt, 32'(lap));
    end
    chk("wcnt_b3", ifb.wrap_cnt, 3);

    // hold at 7 for five cycles
    for (int v = 14; v >= 7; v--) tick(4'(v));
    for (int i = 0; i < 5; i++) begin
      tick(4'd7);
      chk("hold_locked", ifa.locked, 1);
      chk("hold_err", ifa.seq_err, 0);
      chk("hold_ecnt", ifa.err_cnt, 0);
    end
    tick(4'd6); chk("hold_res6", ifa.locked, 1);
    tick(4'd5); chk("hold_res5", ifa.seq_err, 0);
    for (int v = 4; v >= 1; v--) tick(4'(v));
    tick(4'd0);  chk("tc4", ifa.tc_pulse, 1);
    tick(4'd15); chk("wcnt4", ifa.wrap_cnt, 4);
    chk("wcnt_b_sat", ifb.wrap_cnt, 3);

    // glitch 9, 8, 3 then relock on 2, 1
    for (int v = 14; v >= 10; v--) tick(4'(v));
    tick(4'd9);
    tick(4'd8); chk("gl_pre", ifa.locked, 1);
    tick(4'd3);
    chk("gl_err", ifa.seq_err, 1);
    chk("gl_locked", ifa.locked, 0);
    chk("gl_ecnt", ifa.err_cnt, 1);
    chk("gl_ecnt_b", ifb.err_cnt, 1);
    chk("gl_tc", ifa.tc_pulse, 0);
    tick(4'd3); chk("fault_err", ifa.seq_err, 0); chk("fault_locked", ifa.locked, 0);
    tick(4'd2); chk("reacq1", ifa.locked, 0);
    tick(4'd1); chk("relock", ifa.locked, 1);
    tick(4'd0); chk("relock_tc", ifa.tc_pulse, 1);
    tick(4'd15); chk("wcnt5", ifa.wrap_cnt, 5);

    // four more glitches: CNT_W=2 tally saturates at 3
    for (int k = 2; k <= 5; k++) begin
      tick(4'd9);
      chk("sat_err", ifa.seq_err, 1);
      chk("sat_ecnt_a", ifa.err_cnt, 32'(k));
      chk("sat_ecnt_b", ifb.err_cnt, 32'(sat_exp[k-2]));
      tick(4'd9); chk("sat_fault", ifa.locked, 0);
      tick(4'd8); chk("sat_acq", ifa.locked, 0);
      tick(4'd7); chk("sat_relock", ifa.locked, 1);
    end

    // clear coincident with a wrap
    for (int v = 6; v >= 1; v--) tick(4'(v));
    tick(4'd0); chk("clr_pre_tc", ifa.tc_pulse, 1);
    set_clr(1'b1);
    tick(4'd15);
    set_clr(1'b0);
    chk("clr_wrap", ifa.wrap_pulse, 1);
    chk("clr_wcnt", ifa.wrap_cnt, 0);
    chk("clr_ecnt", ifa.err_cnt, 0);
    chk("clr_ecnt_b", ifb.err_cnt, 0);
    chk("clr_locked", ifa.locked, 1);
    tick(4'd14); chk("clr_after", ifa.wrap_cnt, 0);

    // reset mid-TRACK at count 4
    for (int v = 13; v >= 4; v--) tick(4'(v));
    chk("mid_locked", ifa.locked, 1);
    rst = 1'b1;
    tick(4'd3);
    rst = 1'b0;
    chk("mid_locked0", ifa.locked, 0);
    chk("mid_tc0", ifa.tc_pulse, 0);
    chk("mid_wrap0", ifa.wrap_pulse, 0);
    chk("mid_err0", ifa.seq_err, 0);
    chk("mid_ecnt0", ifb.err_cnt, 0);
    tick(4'd2); chk("mid_idle", ifa.locked, 0);
    tick(4'd1); chk("mid_acq", ifa.locked, 0);
    tick(4'd0); chk("mid_relock", ifa.locked, 1); chk("mid_acq_tc", ifa.tc_pulse, 0);
    tick(4'd15); chk("mid_wrap", ifa.wrap_pulse, 1); chk("mid_wcnt", ifa.wrap_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
Downstream consumer of the synchronous down counter's `count` bus. It checks that the sampled value follows a legal decrement sequence and locks onto it. It reports terminal-count (reaching zero) and wrap (0 → max) events as single-cycle pulses. It also keeps saturating wrap and error tallies for status readback or for gating downstream logic.

Parameters:
WIDTH, 4, width of the monitored count bus.
CNT_W, 8, width of the wrap and error tally counters (saturating).
LOCK_N, 2, consecutive legal decrements required to go from ACQUIRE to TRACK (1..7).

Ports:
clk  input  1  rising-edge clock; same clock as the upstream counter.
rst  input  1  synchronous, active-high reset.
count_in  input  WIDTH  value from the upstream down counter.
clr_stats  input  1  synchronous clear of wrap_cnt and err_cnt only.
locked  output  1  high while the FSM is in TRACK.
tc_pulse  output  1  one-cycle pulse: legal step 1 → 0 seen while in TRACK.
wrap_pulse  output  1  one-cycle pulse: legal step 0 → 2^WIDTH-1 seen while in TRACK.
seq_err  output  1  one-cycle pulse on an illegal transition while in TRACK.
wrap_cnt  output  CNT_W  saturating count of wrap_pulse events.
err_cnt  output  CNT_W  saturating count of seq_err events.

Behaviour:
- All outputs are registered; nothing is combinational from `count_in`.
- An internal `prev` register holds the previous sample of `count_in`.
- Definitions, evaluated at each edge with sample `cur = count_in`:
  - `dec` = (cur == prev - 1 mod 2^WIDTH), so prev = 0, cur = max is legal.
  - `hold` = (cur == prev).
- Latency: a transition sampled at edge k produces its pulse or tally change visible immediately after edge k. Effectively, the output lags the counter's step by one clock.
- Reset (rst = 1 at an edge):
  - state = IDLE, prev = 0, locked = 0.
  - tc_pulse, wrap_pulse, seq_err = 0.
  - wrap_cnt = err_cnt = 0, run counter = 0.
  - rst has priority over everything, including mid-TRACK and clr_stats.
- FSM states: IDLE, ACQUIRE, TRACK, FAULT.
  - IDLE: capture prev = cur; go to ACQUIRE next cycle.
  - ACQUIRE:
    - `dec`: run += 1; go to TRACK when run reaches LOCK_N.
    - `hold`: run unchanged.
    - otherwise: run = 0.
    - No pulses and no tallies are generated in ACQUIRE.
  - TRACK:
    - `dec`: stay. Set tc_pulse if cur == 0; set wrap_pulse if prev == 0 (cur == max).
    - `hold`: stay, no pulse. This tolerates an upstream counter held in reset.
    - otherwise: go to FAULT, seq_err = 1, err_cnt += 1.
  - FAULT: lasts exactly one cycle. run = 0; go to ACQUIRE. A sample taken in FAULT only updates prev.
- prev is updated with cur on every non-reset edge, in every state.
- locked = 1 exactly in the cycles the registered state is TRACK. It drops on the same edge that asserts seq_err.
- Saturation: wrap_cnt and err_cnt stop at 2^CNT_W - 1 and never wrap.
- clr_stats:
  - Zeroes both tallies on that edge.
  - If an event occurs on the same edge as clr_stats, the clear wins and the tally reads 0; the pulse output still asserts.
  - Does not affect FSM, prev or locked.
- tc_pulse and wrap_pulse fire on consecutive cycles for the sequence 1 → 0 → max. They never overlap each other or seq_err.

Test Plan:
- Reset then free-run: rst high 10 cycles, then the counter runs 15, 14, … (WIDTH = 4, LOCK_N = 2). Required response:
  - all outputs 0 during reset;
  - locked rises after the 2nd legal decrement;
  - tc_pulse on the 1 → 0 sample;
  - wrap_pulse on the next (0 → 15);
  - wrap_cnt = 1, 2, 3 on successive wraps.
- Hold tolerance: in TRACK, the counter holds at 7 for 5 cycles, then resumes 6, 5. Required response: locked stays 1, seq_err = 0, err_cnt unchanged.
- Glitch: in TRACK, drive 9, 8, 3. Required response:
  - seq_err pulses once on the 3;
  - err_cnt = 1, locked falls;
  - FAULT for 1 cycle, ACQUIRE, then relock after 2 more legal decrements (2, 1 → locked);
  - the 1 → 0 step after relock gives tc_pulse.
- Saturation with CNT_W = 2: force 5 glitches with relock between each. Required response: err_cnt reads 1, 2, 3, 3, 3.
- clr_stats coincident with a wrap: assert clr_stats on the 0 → 15 edge. Required response: wrap_pulse = 1, wrap_cnt = 0 afterwards, locked unchanged.
- Reset mid-operation: assert rst for 1 cycle while in TRACK at count 4. Required response: next cycle all outputs 0, state IDLE; relock requires LOCK_N legal decrements again.
